// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit round-robin arbiter:
//   - arb_state_t : arbiter FSM state encoding (IDLE, SEND, ACK, DRAIN)
//   - EOP_CHAR_DEFAULT : default end-of-packet byte (line feed)
//   - grant_id_w / burst_cnt_w : width helpers for the grant index and the
//     per-grant byte counter, so the interface, top and picker agree.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic [7:0] EOP_CHAR_DEFAULT = 8'h0A;

  // Index width for NUM_SRC sources; never narrower than one bit.
  function automatic int grant_id_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Counter width able to hold 0..max_burst inclusive.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter_if.sv
// uart_tx_rr_arbiter_if
//   Bundles the source-FIFO side, the UART side and the grant status of the
//   round-robin UART arbiter.
//   Signals:
//     src_not_empty [NUM_SRC]       FWFT FIFO data valid, one per source
//     src_data      [NUM_SRC*bits]  FIFO data_out, source i at [i*bits +: bits]
//     src_shift_out [NUM_SRC]       one-hot pop strobe back to the FIFOs
//     tx_data       [bits]          byte to the UART serializer
//     tx_start                      one-cycle start pulse to the UART
//     tx_busy                       UART busy
//     grant_valid                   a source owns the UART
//     grant_id      [ID_W]          owning source index
//     burst_count   [BC_W]          bytes sent in the current grant
//   Modports:
//     master : the arbiter
//     slave  : the surrounding FIFOs / UART / status observer
interface uart_tx_rr_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int bits      = 8,
  parameter int MAX_BURST = 16
);

  localparam int ID_W = grant_id_w(NUM_SRC);
  localparam int BC_W = burst_cnt_w(MAX_BURST);

  logic [NUM_SRC-1:0]      src_not_empty;
  logic [NUM_SRC*bits-1:0] src_data;
  logic [NUM_SRC-1:0]      src_shift_out;
  logic [bits-1:0]         tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic [BC_W-1:0]         burst_count;

  modport master (
    input  src_not_empty, src_data, tx_busy,
    output src_shift_out, tx_data, tx_start, grant_valid, grant_id, burst_count
  );

  modport slave (
    output src_not_empty, src_data, tx_busy,
    input  src_shift_out, tx_data, tx_start, grant_valid, grant_id, burst_count
  );

endinterface

// File: rtl/uart_tx_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first asserted request at
//   or after ptr, wrapping modulo NUM_SRC.
//   Ports:
//     req   in  [NUM_SRC]  request vector
//     ptr   in  [ID_W]     index with highest priority this round
//     found out            at least one request is set
//     idx   out [ID_W]     chosen index (0 when nothing is found)
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = grant_id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  int              cand_int;
  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand_int = 0;
    cand     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand_int = int'(ptr) + k;
      if (cand_int >= NUM_SRC) begin
        cand_int = cand_int - NUM_SRC;
      end
      cand = ID_W'(cand_int);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_rr_arbiter.sv
// uart_tx_rr_arbiter
//   Shares one UART transmitter between NUM_SRC FWFT byte FIFOs. A source is
//   chosen round-robin and keeps the UART until it sends EOP_CHAR, sends
//   MAX_BURST bytes, or its FIFO runs empty. One byte is popped per
//   tx_start; the next byte is only offered after the UART has gone busy
//   and idle again.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     bus    master modport of uart_tx_rr_arbiter_if (FIFO, UART, status)
//   The interface instance must be built with the same NUM_SRC, bits and
//   MAX_BURST as this module.
module uart_tx_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int              NUM_SRC   = 4,
  parameter int              bits      = 8,
  parameter int              MAX_BURST = 16,
  parameter logic [bits-1:0] EOP_CHAR  = bits'(EOP_CHAR_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_rr_arbiter_if.master bus
);

  localparam int ID_W = grant_id_w(NUM_SRC);
  localparam int BC_W = burst_cnt_w(MAX_BURST);

  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_SRC - 1);
  localparam logic [BC_W-1:0] BURST_LIMIT = BC_W'(MAX_BURST);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_ACK   = ACK;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]      state;
  logic            grant_valid_q;
  logic [ID_W-1:0] grant_id_q;
  logic [BC_W-1:0] burst_count_q;
  logic [bits-1:0] tx_data_q;
  logic            tx_start_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic            last_eop_q;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  logic [bits-1:0]    src_word [NUM_SRC];
  logic               sel_ne;
  logic [bits-1:0]    sel_data;
  logic               fire;
  logic               grant_release;
  logic [ID_W-1:0]    next_ptr;
  logic [NUM_SRC-1:0] shift_out;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (bus.src_not_empty),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_word[i] = bus.src_data[i*bits +: bits];
    end
  end

  // The pop strobe is combinational so the FIFO advances on the same edge
  // that captures its head into tx_data.
  always_comb begin
    sel_ne    = bus.src_not_empty[grant_id_q];
    sel_data  = src_word[grant_id_q];
    fire      = (state == ST_SEND) && sel_ne && !bus.tx_busy;
    shift_out = '0;
    if (fire) begin
      shift_out[grant_id_q] = 1'b1;
    end
  end

  // A grant ends when the owner runs dry while waiting to send, or once the
  // UART has finished a byte that closed the packet, hit the burst limit,
  // or left the FIFO empty.
  always_comb begin
    grant_release = 1'b0;
    if (state == ST_SEND && !sel_ne) begin
      grant_release = 1'b1;
    end
    if (state == ST_DRAIN && !bus.tx_busy &&
        (last_eop_q || burst_count_q == BURST_LIMIT || !sel_ne)) begin
      grant_release = 1'b1;
    end
    next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      burst_count_q <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      rr_ptr_q      <= '0;
      last_eop_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (grant_release) begin
        // Releasing source drops to lowest priority for the next round.
        grant_valid_q <= 1'b0;
        rr_ptr_q      <= next_ptr;
        state         <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pick_found) begin
              grant_id_q    <= pick_idx;
              grant_valid_q <= 1'b1;
              burst_count_q <= '0;
              state         <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (fire) begin
              tx_data_q     <= sel_data;
              tx_start_q    <= 1'b1;
              burst_count_q <= burst_count_q + 1'b1;
              last_eop_q    <= (sel_data == EOP_CHAR);
              state         <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (bus.tx_busy) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (!bus.tx_busy) begin
              state <= ST_SEND;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.src_shift_out = shift_out;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.burst_count   = burst_count_q;

endmodule
